// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the instruction/data memory port arbiter.
//   state_t        : arbiter FSM states (IDLE, BUSY_D, BUSY_I)
//   MAX_WAIT_DEF   : default BUSY cycles without mem_ack before an access is aborted
//   STARVE_LIM_DEF : default data grants allowed in a row while a fetch waits
package mem_arb_pkg;
    localparam int MAX_WAIT_DEF = 15;
    localparam int STARVE_LIM_DEF = 4;
    typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_t;
endpackage

// File: rtl/wait_timer.sv
// wait_timer: counts BUSY cycles without a memory acknowledge.
//   clk, reset : clock, synchronous active-low reset
//   clear      : restart the count (asserted when an access is granted)
//   enable     : count this cycle (BUSY and no mem_ack)
//   expired    : count has reached MAX_WAIT
module wait_timer import mem_arb_pkg::*; #(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(MAX_WAIT + 1);
    logic [W-1:0] count;
    always_ff @(posedge clk) begin
        if (!reset || clear) count <= '0;
        else if (enable && !expired) count <= count + 1'b1;
    end
    assign expired = count == W'(MAX_WAIT);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch and data access.
//   clk, reset                       : clock, synchronous active-low reset
//   if_req/if_addr -> if_rdata/if_ready  : fetch port
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_ready : data port
//   stall_f, stall_m                 : pipeline stall indications per port
//   mem_req/mem_we/mem_addr/mem_wdata, mem_rdata/mem_ack : memory side
//   bus_err                          : sticky flag, set when an access times out
module mem_port_arbiter import mem_arb_pkg::*; #(
    parameter int MAX_WAIT = MAX_WAIT_DEF,
    parameter int STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        stall_f,
    output logic        stall_m,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err
);
    state_t state;
    logic [2:0] streak;
    logic busy, expired, done, grant_d, grant_i;

    assign busy = state != IDLE;
    // An ack in the timeout cycle wins: it completes normally with real data.
    assign done = busy && (mem_ack || expired);
    // Data has priority unless fetch has already lost STARVE_LIM grants in a row.
    assign grant_d = state == IDLE && d_req && !(if_req && streak == 3'(STARVE_LIM));
    assign grant_i = state == IDLE && if_req && !grant_d;

    wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .clk(clk),
        .reset(reset),
        .clear(grant_d || grant_i),
        .enable(busy && !mem_ack),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            streak <= '0;
            bus_err <= 1'b0;
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
        end else if (grant_d || grant_i) begin
            state <= grant_d ? BUSY_D : BUSY_I;
            mem_req <= 1'b1;
            mem_we <= grant_d && d_we;
            mem_addr <= grant_d ? d_addr : if_addr;
            mem_wdata <= grant_d ? d_wdata : '0;
            // A data grant with fetch waiting is only possible below the limit, so +1 never overshoots.
            streak <= (grant_d && if_req) ? streak + 3'd1 : 3'd0;
        end else if (done) begin
            state <= IDLE;
            mem_req <= 1'b0;
            if (!mem_ack) bus_err <= 1'b1;
        end
    end

    assign d_ready = state == BUSY_D && done;
    assign if_ready = state == BUSY_I && done;
    // A timeout completes with zero data; only a real ack passes memory data through.
    assign d_rdata = (d_ready && mem_ack) ? mem_rdata : '0;
    assign if_rdata = (if_ready && mem_ack) ? mem_rdata : '0;
    assign stall_f = if_req && !if_ready;
    assign stall_m = d_req && !d_ready;
endmodule
